dsp_rst_sequencer: RTL and testbench

//  Consumes the DSP watchdog outputs (WD_RST, WD_DSP_ERR) and drives the DSP reset pin.

---
 rtl/dsp_rst_sequencer.sv | 139 +++++++++++++
 tb/tb_dsp_rst_sequencer.sv | 376 +++++++++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/dsp_rst_sequencer.sv
// DSP reset sequencer: power-on hold, boot grace, run, with watchdog-triggered
// re-resets, event counting and lockout after repeated events without a stable run window.
//
// state    | meaning
// ---------+-----------------------------------------------------------
// POR_HOLD | DSP held in reset for PorTime+1 cycles after reset/clear
// BOOT     | DSP released, watchdog ignored for BootGrace+1 cycles
// RUN      | normal operation, watchdog events counted
// WD_HOLD  | DSP re-reset for HoldTime+1 cycles after a watchdog event
// LOCKOUT  | DSP held in reset until the host pulses clr_fault
`timescale 1ns/1ps
module dsp_rst_sequencer #(
    parameter int unsigned PorTime    = 19999,
    parameter int unsigned BootGrace  = 199999,
    parameter int unsigned HoldTime   = 19999,
    parameter int unsigned StableTime = 1999999,
    parameter int unsigned MaxResets  = 3
) (
    input  logic       clk_20M,
    input  logic       reset_n,
    input  logic       WD_RST,
    input  logic       WD_DSP_ERR,
    input  logic       clr_fault,
    output logic       DSP_RST_n,
    output logic       dsp_run,
    output logic       fault_lock,
    output logic       err_seen,
    output logic [7:0] rst_total
);

    localparam logic [23:0] POR_T    = 24'(PorTime);
    localparam logic [23:0] BOOT_T   = 24'(BootGrace);
    localparam logic [23:0] HOLD_T   = 24'(HoldTime);
    localparam logic [23:0] STABLE_T = 24'(StableTime);
    localparam logic [4:0]  MAX_R    = 5'(MaxResets);

    typedef enum logic [2:0] {
        POR_HOLD = 3'd0,
        BOOT     = 3'd1,
        RUN      = 3'd2,
        WD_HOLD  = 3'd3,
        LOCKOUT  = 3'd4
    } state_t;

    state_t      state;
    state_t      state_nxt;
    logic [23:0] timer;
    logic [23:0] timer_nxt;
    logic [3:0]  consec;
    logic [3:0]  consec_nxt;
    logic [7:0]  rst_total_nxt;
    logic        err_seen_nxt;
    logic        wd_q;
    logic        wd_qq;
    logic        evt;

    // Rising edge of the synchronised request; a level held high gives one event.
    assign evt = wd_q & ~wd_qq;

    always_comb begin
        state_nxt     = state;
        consec_nxt    = consec;
        rst_total_nxt = rst_total;
        timer_nxt     = timer;
        err_seen_nxt  = err_seen;

        case (state)
            POR_HOLD: begin
                if (timer == POR_T) state_nxt = BOOT;
            end
            BOOT: begin
                if (timer == BOOT_T) state_nxt = RUN;
            end
            RUN: begin
                if (evt) begin
                    rst_total_nxt = (rst_total == 8'hFF) ? rst_total : rst_total + 8'd1;
                    consec_nxt    = (consec == 4'hF) ? consec : consec + 4'd1;
                    state_nxt     = (({1'b0, consec} + 5'd1) >= MAX_R) ? LOCKOUT : WD_HOLD;
                end else if (timer == STABLE_T) begin
                    consec_nxt = '0;
                end
            end
            WD_HOLD: begin
                if (timer == HOLD_T) state_nxt = BOOT;
            end
            LOCKOUT: begin
                if (clr_fault) begin
                    state_nxt  = POR_HOLD;
                    consec_nxt = '0;
                end
            end
            default: state_nxt = POR_HOLD;
        endcase

        // Timer restarts on every transition; it rests at StableTime in RUN and idles in LOCKOUT.
        if (state_nxt != state) begin
            timer_nxt = '0;
        end else if (state == LOCKOUT) begin
            timer_nxt = timer;
        end else if ((state == RUN) && (timer == STABLE_T)) begin
            timer_nxt = timer;
        end else begin
            timer_nxt = timer + 24'd1;
        end

        if ((state == RUN) && WD_DSP_ERR) begin
            err_seen_nxt = 1'b1;
        end else if (clr_fault) begin
            err_seen_nxt = 1'b0;
        end
    end

    always_ff @(posedge clk_20M or negedge reset_n) begin
        if (!reset_n) begin
            state      <= POR_HOLD;
            timer      <= '0;
            consec     <= '0;
            wd_q       <= 1'b0;
            wd_qq      <= 1'b0;
            DSP_RST_n  <= 1'b0;
            dsp_run    <= 1'b0;
            fault_lock <= 1'b0;
            err_seen   <= 1'b0;
            rst_total  <= '0;
        end else begin
            state      <= state_nxt;
            timer      <= timer_nxt;
            consec     <= consec_nxt;
            wd_q       <= WD_RST;
            wd_qq      <= wd_q;
            DSP_RST_n  <= (state_nxt == BOOT) || (state_nxt == RUN);
            dsp_run    <= (state_nxt == RUN);
            fault_lock <= (state_nxt == LOCKOUT);
            err_seen   <= err_seen_nxt;
            rst_total  <= rst_total_nxt;
        end
    end

endmodule

// File: tb/tb_dsp_rst_sequencer.sv
// Scoreboard bench for dsp_rst_sequencer with shortened timing parameters.
`timescale 1ns/1ps
module tb_dsp_rst_sequencer;

    localparam int POR_TIME    = 9;
    localparam int BOOT_GRACE  = 19;
    localparam int HOLD_TIME   = 4;
    localparam int STABLE_TIME = 49;
    localparam int MAX_RESETS  = 3;
    localparam int BUDGET      = 300;

    logic       clk_20M;
    logic       reset_n;
    logic       WD_RST;
    logic       WD_DSP_ERR;
    logic       clr_fault;
    logic       DSP_RST_n;
    logic       dsp_run;
    logic       fault_lock;
    logic       err_seen;
    logic [7:0] rst_total;

    typedef struct packed {
        logic       lock;
        logic [7:0] total;
    } exp_t;

    exp_t sb_q[$];
    int   m_total;
    int   m_consec;
    int   n_tests;
    int   n_fail;

    dsp_rst_sequencer #(
        .PorTime    (POR_TIME),
        .BootGrace  (BOOT_GRACE),
        .HoldTime   (HOLD_TIME),
        .StableTime (STABLE_TIME),
        .MaxResets  (MAX_RESETS)
    ) dut (
        .clk_20M    (clk_20M),
        .reset_n    (reset_n),
        .WD_RST     (WD_RST),
        .WD_DSP_ERR (WD_DSP_ERR),
        .clr_fault  (clr_fault),
        .DSP_RST_n  (DSP_RST_n),
        .dsp_run    (dsp_run),
        .fault_lock (fault_lock),
        .err_seen   (err_seen),
        .rst_total  (rst_total)
    );

    initial clk_20M = 1'b0;
    always #25 clk_20M = ~clk_20M;

    task automatic tick();
        @(posedge clk_20M);
        #1;
    endtask

    task automatic apply_reset();
        reset_n    = 1'b0;
        WD_RST     = 1'b0;
        WD_DSP_ERR = 1'b0;
        clr_fault  = 1'b0;
        m_total    = 0;
        m_consec   = 0;
        sb_q.delete();
        tick();
        tick();
        reset_n = 1'b1;
    endtask

    task automatic wait_release(output int cycles);
        cycles = 0;
        while ((DSP_RST_n !== 1'b1) && (cycles < BUDGET)) begin
            tick();
            cycles++;
        end
    endtask

    task automatic wait_run(output int cycles);
        cycles = 0;
        while ((dsp_run !== 1'b1) && (cycles < BUDGET)) begin
            tick();
            cycles++;
        end
    endtask

    // Reference model of one watchdog event seen in RUN.
    task automatic sb_push();
        exp_t e;
        e.lock   = ((m_consec + 1) >= MAX_RESETS);
        m_consec = m_consec + 1;
        m_total  = (m_total >= 255) ? 255 : m_total + 1;
        e.total  = 8'(m_total);
        sb_q.push_back(e);
    endtask

    // Waits w cycles in RUN, then drives a len-cycle WD_RST pulse (len >= 2).
    task automatic drive_pulse(input int w, input int len);
        repeat (w) tick();
        if (w > STABLE_TIME + 5) m_consec = 0;
        sb_push();
        WD_RST = 1'b1;
        repeat (len) tick();
        WD_RST = 1'b0;
    endtask

    task automatic test_reset();
        int cyc;
        reset_n    = 1'b1;
        WD_RST     = 1'b0;
        WD_DSP_ERR = 1'b0;
        clr_fault  = 1'b0;
        m_total    = 0;
        m_consec   = 0;
        #5 reset_n = 1'b0;
        #5;
        n_tests++;
        if ({DSP_RST_n, dsp_run, fault_lock, err_seen, rst_total} !== 12'h000) begin
            n_fail++;
            $display("FAIL reset_values: got %b %b %b %b %0d, expected 0 0 0 0 0",
                     DSP_RST_n, dsp_run, fault_lock, err_seen, rst_total);
        end
        tick();
        tick();
        reset_n = 1'b1;
        wait_release(cyc);
        n_tests++;
        if (cyc !== POR_TIME + 1) begin
            n_fail++;
            $display("FAIL por_hold_len: got %0d cycles, expected %0d", cyc, POR_TIME + 1);
        end
        wait_run(cyc);
        n_tests++;
        if (cyc !== BOOT_GRACE + 1) begin
            n_fail++;
            $display("FAIL boot_len: got %0d cycles, expected %0d", cyc, BOOT_GRACE + 1);
        end
    endtask

    task automatic test_single_pulse();
        int   cyc;
        exp_t e;
        sb_push();
        WD_RST = 1'b1;
        tick();
        n_tests++;
        if (DSP_RST_n !== 1'b1) begin
            n_fail++;
            $display("FAIL evt_latency_early: DSP_RST_n got %b, expected 1", DSP_RST_n);
        end
        tick();
        e = sb_q.pop_front();
        n_tests++;
        if ((DSP_RST_n !== 1'b0) || (fault_lock !== e.lock) || (rst_total !== e.total)) begin
            n_fail++;
            $display("FAIL single_evt: got rst_n=%b lock=%b total=%0d, expected 0 %b %0d",
                     DSP_RST_n, fault_lock, rst_total, e.lock, e.total);
        end
        tick();
        WD_RST = 1'b0;
        wait_release(cyc);
        // Two hold cycles are already behind us at this point.
        n_tests++;
        if (cyc !== HOLD_TIME + 1 - 2 + 1) begin
            n_fail++;
            $display("FAIL hold_len: got %0d cycles, expected %0d", cyc, HOLD_TIME);
        end
        wait_run(cyc);
        n_tests++;
        if (cyc !== BOOT_GRACE + 1) begin
            n_fail++;
            $display("FAIL reboot_len: got %0d cycles, expected %0d", cyc, BOOT_GRACE + 1);
        end
    endtask

    task automatic test_lockout();
        int   cyc;
        int   bad;
        int   waits[3] = '{5, 10, 20};
        exp_t e;
        apply_reset();
        wait_release(cyc);
        wait_run(cyc);
        for (int k = 0; k < 3; k++) begin
            if (k > 0) wait_run(cyc);
            drive_pulse(waits[k], 3);
            e = sb_q.pop_front();
            n_tests++;
            if ((DSP_RST_n !== 1'b0) || (fault_lock !== e.lock) || (rst_total !== e.total)) begin
                n_fail++;
                $display("FAIL lockout_evt%0d: got rst_n=%b lock=%b total=%0d, expected 0 %b %0d",
                         k, DSP_RST_n, fault_lock, rst_total, e.lock, e.total);
            end
        end
        bad = 0;
        for (int i = 0; i < 1000; i++) begin
            if (i == 500) WD_RST = 1'b1;
            if (i == 503) WD_RST = 1'b0;
            tick();
            if ((DSP_RST_n !== 1'b0) || (fault_lock !== 1'b1)) bad++;
        end
        n_tests++;
        if ((bad !== 0) || (rst_total !== 8'(m_total))) begin
            n_fail++;
            $display("FAIL lockout_hold: got %0d bad cycles total=%0d, expected 0 bad total=%0d",
                     bad, rst_total, m_total);
        end
        clr_fault = 1'b1;
        tick();
        clr_fault = 1'b0;
        m_consec  = 0;
        n_tests++;
        if ((fault_lock !== 1'b0) || (DSP_RST_n !== 1'b0) || (rst_total !== 8'd3)) begin
            n_fail++;
            $display("FAIL clr_fault: got lock=%b rst_n=%b total=%0d, expected 0 0 3",
                     fault_lock, DSP_RST_n, rst_total);
        end
        wait_release(cyc);
        n_tests++;
        if (cyc !== POR_TIME + 1) begin
            n_fail++;
            $display("FAIL clr_por_len: got %0d cycles, expected %0d", cyc, POR_TIME + 1);
        end
        wait_run(cyc);
    endtask

    task automatic test_spaced();
        int   cyc;
        exp_t e;
        apply_reset();
        wait_release(cyc);
        for (int k = 0; k < 10; k++) begin
            wait_run(cyc);
            drive_pulse(60, 2);
            e = sb_q.pop_front();
            n_tests++;
            if ((DSP_RST_n !== 1'b0) || (fault_lock !== e.lock) || (rst_total !== e.total)) begin
                n_fail++;
                $display("FAIL spaced_evt%0d: got rst_n=%b lock=%b total=%0d, expected 0 %b %0d",
                         k, DSP_RST_n, fault_lock, rst_total, e.lock, e.total);
            end
        end
        n_tests++;
        if ((rst_total !== 8'd10) || (fault_lock !== 1'b0)) begin
            n_fail++;
            $display("FAIL spaced_total: got total=%0d lock=%b, expected 10 0", rst_total, fault_lock);
        end
    endtask

    task automatic test_level_and_err();
        int cyc;
        wait_release(cyc);
        WD_RST = 1'b1;
        wait_run(cyc);
        repeat (30) tick();
        n_tests++;
        if ((rst_total !== 8'(m_total)) || (dsp_run !== 1'b1) || (DSP_RST_n !== 1'b1)) begin
            n_fail++;
            $display("FAIL level_into_run: got total=%0d run=%b rst_n=%b, expected %0d 1 1",
                     rst_total, dsp_run, DSP_RST_n, m_total);
        end
        WD_RST = 1'b0;
        repeat (5) tick();
        n_tests++;
        if ((err_seen !== 1'b0) || (dsp_run !== 1'b1)) begin
            n_fail++;
            $display("FAIL err_idle: got err=%b run=%b, expected 0 1", err_seen, dsp_run);
        end
        WD_DSP_ERR = 1'b1;
        tick();
        WD_DSP_ERR = 1'b0;
        n_tests++;
        if (err_seen !== 1'b1) begin
            n_fail++;
            $display("FAIL err_set: got %b, expected 1", err_seen);
        end
        clr_fault = 1'b1;
        tick();
        clr_fault = 1'b0;
        n_tests++;
        if ((err_seen !== 1'b0) || (dsp_run !== 1'b1) || (fault_lock !== 1'b0)) begin
            n_fail++;
            $display("FAIL err_clr: got err=%b run=%b lock=%b, expected 0 1 0",
                     err_seen, dsp_run, fault_lock);
        end
        WD_DSP_ERR = 1'b1;
        clr_fault  = 1'b1;
        tick();
        WD_DSP_ERR = 1'b0;
        clr_fault  = 1'b0;
        n_tests++;
        if (err_seen !== 1'b1) begin
            n_fail++;
            $display("FAIL err_set_wins: got %b, expected 1", err_seen);
        end
        clr_fault = 1'b1;
        tick();
        clr_fault = 1'b0;
        n_tests++;
        if (err_seen !== 1'b0) begin
            n_fail++;
            $display("FAIL err_reclr: got %b, expected 0", err_seen);
        end
    endtask

    task automatic test_async_reset_and_saturation();
        int   cyc;
        exp_t e;
        drive_pulse(60, 3);
        e = sb_q.pop_front();
        n_tests++;
        if ((DSP_RST_n !== 1'b0) || (fault_lock !== e.lock) || (rst_total !== e.total)) begin
            n_fail++;
            $display("FAIL pre_reset_evt: got rst_n=%b lock=%b total=%0d, expected 0 %b %0d",
                     DSP_RST_n, fault_lock, rst_total, e.lock, e.total);
        end
        #10 reset_n = 1'b0;
        #1;
        n_tests++;
        if ({DSP_RST_n, dsp_run, fault_lock, err_seen, rst_total} !== 12'h000) begin
            n_fail++;
            $display("FAIL async_reset: got %b %b %b %b %0d, expected 0 0 0 0 0",
                     DSP_RST_n, dsp_run, fault_lock, err_seen, rst_total);
        end
        m_total  = 0;
        m_consec = 0;
        tick();
        tick();
        reset_n = 1'b1;
        wait_release(cyc);
        n_tests++;
        if (cyc !== POR_TIME + 1) begin
            n_fail++;
            $display("FAIL restart_por_len: got %0d cycles, expected %0d", cyc, POR_TIME + 1);
        end
        wait_run(cyc);
        n_tests++;
        if (cyc !== BOOT_GRACE + 1) begin
            n_fail++;
            $display("FAIL restart_boot_len: got %0d cycles, expected %0d", cyc, BOOT_GRACE + 1);
        end
        for (int k = 0; k < 260; k++) begin
            if (k > 0) wait_run(cyc);
            drive_pulse(55, 2);
            e = sb_q.pop_front();
            n_tests++;
            if ((DSP_RST_n !== 1'b0) || (fault_lock !== e.lock) || (rst_total !== e.total)) begin
                n_fail++;
                $display("FAIL sat_evt%0d: got rst_n=%b lock=%b total=%0d, expected 0 %b %0d",
                         k, DSP_RST_n, fault_lock, rst_total, e.lock, e.total);
            end
        end
        n_tests++;
        if (rst_total !== 8'd255) begin
            n_fail++;
            $display("FAIL sat_total: got %0d, expected 255", rst_total);
        end
    endtask

    initial begin
        n_tests = 0;
        n_fail  = 0;
        test_reset();
        test_single_pulse();
        test_lockout();
        test_spaced();
        test_level_and_err();
        test_async_reset_and_saturation();
        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule
